q15_cplx_div: RTL and testbench

//   Sequential Q15 complex divider c = a / b: the inverse of the Q15 complex multiply.

---
 rtl/q15_cplx_div_pkg.sv | 33 +++
 rtl/q15_cplx_div_if.sv | 26 ++
 rtl/q15_cplx_div_frac_div.sv | 57 +++++
 rtl/q15_cplx_div.sv | 142 ++++++++++++++
 tb/tb_q15_cplx_div.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/q15_cplx_div_pkg.sv
// rtl/q15_cplx_div_pkg.sv - shared Q15 complex types, constants and FSM encoding for the complex divider
package q15_cplx_div_pkg;

    typedef logic signed [15:0] q15_t;

    typedef struct packed {
        q15_t re;
        q15_t im;
    } cplx_q15_t;

    localparam q15_t Q15_MAX = 16'sd32767;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        DIV,
        DONE
    } state_t;

    function automatic logic [31:0] mag33(input logic signed [32:0] v);
        logic signed [32:0] neg_v;
        neg_v = -v;
        return v[32] ? neg_v[31:0] : v[31:0];
    endfunction

    // Saturated results clip symmetrically so -32768 is never produced.
    function automatic q15_t apply_sign(input logic neg, input logic sat, input logic [14:0] q);
        q15_t m;
        m = sat ? Q15_MAX : $signed({1'b0, q});
        return neg ? -m : m;
    endfunction

endpackage

// File: rtl/q15_cplx_div_if.sv
// rtl/q15_cplx_div_if.sv - operand/result valid-ready bus of the complex divider
interface q15_cplx_div_if;
    import q15_cplx_div_pkg::*;

    logic      in_valid;
    logic      in_ready;
    cplx_q15_t a;
    cplx_q15_t b;
    logic      out_valid;
    logic      out_ready;
    cplx_q15_t c;
    logic      sat_re;
    logic      sat_im;
    logic      div_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, sat_re, sat_im, div_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, sat_re, sat_im, div_zero
    );

endinterface

// File: rtl/q15_cplx_div_frac_div.sv
// rtl/q15_cplx_div_frac_div.sv - unsigned fractional restoring divider, q = floor(num * 2^15 / den)
module q15_cplx_div_frac_div #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [31:0] num,
    input  logic [31:0] den,
    output logic [14:0] q,
    output logic        done
);

    localparam int         K     = 15 / BITS_PER_CYCLE;
    localparam logic [3:0] K_CNT = 4'(K);

    logic [32:0] rem_q, rem_d, rem_w;
    logic [14:0] q_q, q_d, quo_w;
    logic [3:0]  cnt_q, cnt_d;
    logic        step;

    // The first group of quotient bits is produced on the start edge itself,
    // so the final bits are registered after K edges.
    always_comb begin
        step  = start || (cnt_q != K_CNT);
        rem_w = start ? {1'b0, num} : rem_q;
        quo_w = start ? '0 : q_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_w = {rem_w[31:0], 1'b0};
            if (rem_w >= {1'b0, den}) begin
                rem_w = rem_w - {1'b0, den};
                quo_w = {quo_w[13:0], 1'b1};
            end else begin
                quo_w = {quo_w[13:0], 1'b0};
            end
        end
        rem_d = step ? rem_w : rem_q;
        q_d   = step ? quo_w : q_q;
        cnt_d = start ? 4'd1 : ((cnt_q != K_CNT) ? cnt_q + 4'd1 : cnt_q);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rem_q <= '0;
            q_q   <= '0;
            cnt_q <= K_CNT;
        end else begin
            rem_q <= rem_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q    = q_q;
    assign done = (cnt_q == K_CNT);

endmodule

// File: rtl/q15_cplx_div.sv
// rtl/q15_cplx_div.sv - sequential Q15 complex divider c = a * conj(b) / |b|^2
module q15_cplx_div
    import q15_cplx_div_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           arst_n,
    q15_cplx_div_if.slave  bus
);

    state_t    state_q, state_d;
    cplx_q15_t a_q, a_d, b_q, b_d;
    logic      neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic      sat_re_pend_q, sat_re_pend_d, sat_im_pend_q, sat_im_pend_d;
    logic      dz_pend_q, dz_pend_d;
    cplx_q15_t c_q, c_d;
    logic      sat_re_q, sat_re_d, sat_im_q, sat_im_d, div_zero_q, div_zero_d;

    logic signed [31:0] p_rr, p_ii, p_ir, p_ri, p_br, p_bi;
    logic signed [32:0] num_re, num_im;
    logic [31:0]        den, mag_re, mag_im, div_num_re, div_num_im;
    logic               dz_w, sat_re_w, sat_im_w;
    logic [14:0]        q_re, q_im;
    logic               done_re, done_im;

    assign p_rr   = 32'(a_q.re) * 32'(b_q.re);
    assign p_ii   = 32'(a_q.im) * 32'(b_q.im);
    assign p_ir   = 32'(a_q.im) * 32'(b_q.re);
    assign p_ri   = 32'(a_q.re) * 32'(b_q.im);
    assign p_br   = 32'(b_q.re) * 32'(b_q.re);
    assign p_bi   = 32'(b_q.im) * 32'(b_q.im);
    assign num_re = 33'(p_rr) + 33'(p_ii);
    assign num_im = 33'(p_ir) - 33'(p_ri);
    assign den    = $unsigned(p_br) + $unsigned(p_bi);
    assign mag_re = mag33(num_re);
    assign mag_im = mag33(num_im);

    assign dz_w     = (den == 32'd0);
    assign sat_re_w = !dz_w && (mag_re >= den);
    assign sat_im_w = !dz_w && (mag_im >= den);

    // Dividers only ever see a proper fraction; other cases are resolved in PREP.
    assign div_num_re = (dz_w || sat_re_w) ? '0 : mag_re;
    assign div_num_im = (dz_w || sat_im_w) ? '0 : mag_im;

    q15_cplx_div_frac_div #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_div_re (
        .clk(clk), .arst_n(arst_n), .start(state_q == PREP),
        .num(div_num_re), .den(den), .q(q_re), .done(done_re)
    );

    q15_cplx_div_frac_div #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_div_im (
        .clk(clk), .arst_n(arst_n), .start(state_q == PREP),
        .num(div_num_im), .den(den), .q(q_im), .done(done_im)
    );

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        neg_re_d      = neg_re_q;
        neg_im_d      = neg_im_q;
        sat_re_pend_d = sat_re_pend_q;
        sat_im_pend_d = sat_im_pend_q;
        dz_pend_d     = dz_pend_q;
        c_d           = c_q;
        sat_re_d      = sat_re_q;
        sat_im_d      = sat_im_q;
        div_zero_d    = div_zero_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = PREP;
                end
            end
            PREP: begin
                neg_re_d      = num_re[32];
                neg_im_d      = num_im[32];
                sat_re_pend_d = sat_re_w;
                sat_im_pend_d = sat_im_w;
                dz_pend_d     = dz_w;
                state_d       = DIV;
            end
            DIV: begin
                if (done_re && done_im) begin
                    c_d.re     = dz_pend_q ? '0 : apply_sign(neg_re_q, sat_re_pend_q, q_re);
                    c_d.im     = dz_pend_q ? '0 : apply_sign(neg_im_q, sat_im_pend_q, q_im);
                    sat_re_d   = sat_re_pend_q;
                    sat_im_d   = sat_im_pend_q;
                    div_zero_d = dz_pend_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            neg_re_q      <= 1'b0;
            neg_im_q      <= 1'b0;
            sat_re_pend_q <= 1'b0;
            sat_im_pend_q <= 1'b0;
            dz_pend_q     <= 1'b0;
            c_q           <= '0;
            sat_re_q      <= 1'b0;
            sat_im_q      <= 1'b0;
            div_zero_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            neg_re_q      <= neg_re_d;
            neg_im_q      <= neg_im_d;
            sat_re_pend_q <= sat_re_pend_d;
            sat_im_pend_q <= sat_im_pend_d;
            dz_pend_q     <= dz_pend_d;
            c_q           <= c_d;
            sat_re_q      <= sat_re_d;
            sat_im_q      <= sat_im_d;
            div_zero_q    <= div_zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.c         = c_q;
    assign bus.sat_re    = sat_re_q;
    assign bus.sat_im    = sat_im_q;
    assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_q15_cplx_div.sv
// tb/tb_q15_cplx_div.sv - scoreboard bench for q15_cplx_div at 1 and 5 quotient bits per cycle
module tb_q15_cplx_div;
    import q15_cplx_div_pkg::*;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    q15_cplx_div_if bus0();
    q15_cplx_div_if bus1();

    q15_cplx_div #(.BITS_PER_CYCLE(1)) dut0 (.clk(clk), .arst_n(arst_n), .bus(bus0.slave));
    q15_cplx_div #(.BITS_PER_CYCLE(5)) dut1 (.clk(clk), .arst_n(arst_n), .bus(bus1.slave));

    typedef struct packed {
        logic [31:0] c;
        logic        sr;
        logic        si;
        logic        dz;
    } res_t;

    typedef struct packed {
        res_t        r;
        logic [31:0] acc;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    bit          seen0 = 1'b0;
    bit          seen1 = 1'b0;
    bit          rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [31:0] c, input logic sr, input logic si, input logic dz);
        res_t r;
        r.c = c; r.sr = sr; r.si = si; r.dz = dz;
        return r;
    endfunction

    // Reference: exact quotient of the complex division scaled by 2^15, truncated toward zero.
    function automatic res_t model(input logic [31:0] av, input logic [31:0] bv);
        longint ar, ai, br, bi, nr, ni, den, mr, mi, vr, vi;
        res_t   r;
        ar = longint'($signed(av[31:16])); ai = longint'($signed(av[15:0]));
        br = longint'($signed(bv[31:16])); bi = longint'($signed(bv[15:0]));
        nr  = ar * br + ai * bi;
        ni  = ai * br - ar * bi;
        den = br * br + bi * bi;
        r = '0;
        if (den == 0) begin
            r.dz = 1'b1;
            return r;
        end
        mr = (nr < 0) ? -nr : nr;
        mi = (ni < 0) ? -ni : ni;
        r.sr = (mr >= den);
        r.si = (mi >= den);
        vr = r.sr ? 32767 : (mr * 32768) / den;
        vi = r.si ? 32767 : (mi * 32768) / den;
        if (nr < 0) vr = -vr;
        if (ni < 0) vi = -vi;
        r.c = {16'(vr), 16'(vi)};
        return r;
    endfunction

    // Offers one operand pair to both instances; called and returns at posedge+1.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input res_t e);
        exp_t x;
        bit   acc0, acc1;
        bus0.a = av; bus0.b = bv; bus1.a = av; bus1.b = bv;
        bus0.in_valid = 1'b1;
        bus1.in_valid = 1'b1;
        for (int t = 0; t < 400 && (bus0.in_valid || bus1.in_valid); t++) begin
            @(negedge clk);
            acc0 = bus0.in_valid && bus0.in_ready && arst_n;
            acc1 = bus1.in_valid && bus1.in_ready && arst_n;
            @(posedge clk);
            #1;
            x.r = e;
            x.acc = cyc;
            if (acc0) begin bus0.in_valid = 1'b0; q0.push_back(x); end
            if (acc1) begin bus1.in_valid = 1'b0; q1.push_back(x); end
        end
        if (bus0.in_valid || bus1.in_valid) begin
            errors++; checks++;
            $display("FAIL accept_timeout: got in_valid pending expected accepted");
        end
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_rdy = 1'b0;
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        for (int t = 0; t < 200 && (q0.size() != 0 || q1.size() != 0); t++) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q0.size(), q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (arst_n && bus0.out_valid) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon0_unexpected: got out_valid 1 expected 0");
            end else begin
                if (!seen0) begin
                    seen0 = 1'b1;
                    chk("latency0", 64'(cyc - q0[0].acc), 64'd16);
                end
                if (bus0.out_ready) begin
                    chk("result0", 64'({bus0.c, bus0.sat_re, bus0.sat_im, bus0.div_zero}), 64'(q0[0].r));
                    void'(q0.pop_front());
                    seen0 = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (arst_n && bus1.out_valid) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon1_unexpected: got out_valid 1 expected 0");
            end else begin
                if (!seen1) begin
                    seen1 = 1'b1;
                    chk("latency1", 64'(cyc - q1[0].acc), 64'd4);
                end
                if (bus1.out_ready) begin
                    chk("result1", 64'({bus1.c, bus1.sat_re, bus1.sat_im, bus1.div_zero}), 64'(q1[0].r));
                    void'(q1.pop_front());
                    seen1 = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            bus0.out_ready = ($urandom % 4) != 0;
            bus1.out_ready = ($urandom % 4) != 0;
        end
    end

    function automatic logic [15:0] rnd_part(input int mode);
        logic [15:0] pick [5];
        pick[0] = 16'h8000; pick[1] = 16'h7FFF; pick[2] = 16'h0000;
        pick[3] = 16'h0001; pick[4] = 16'hFFFF;
        case (mode)
            1:       return 16'($signed($urandom_range(0, 128)) - 64);
            3:       return pick[$urandom_range(0, 4)];
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] av, bv, cap;
        int          bad, mode;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        @(negedge clk);
        chk("reset0", 64'({bus0.in_ready, bus0.out_valid, bus0.c, bus0.sat_re, bus0.sat_im, bus0.div_zero}), 64'({1'b1, 1'b0, 35'd0}));
        chk("reset1", 64'({bus1.in_ready, bus1.out_valid, bus1.c, bus1.sat_re, bus1.sat_im, bus1.div_zero}), 64'({1'b1, 1'b0, 35'd0}));
        @(posedge clk);
        #1;

        send(32'h2000_0000, 32'h4000_0000, mk(32'h4000_0000, 1'b0, 1'b0, 1'b0));
        send(32'h1000_2000, 32'h0000_4000, mk(32'h4000_E000, 1'b0, 1'b0, 1'b0));
        send(32'h4000_4000, 32'h0000_4000, mk(32'h7FFF_8001, 1'b1, 1'b1, 1'b0));
        send(32'h1234_5678, 32'h0000_0000, mk(32'h0000_0000, 1'b0, 1'b0, 1'b1));
        send(32'hE000_0000, 32'h4000_0000, mk(32'hC000_0000, 1'b0, 1'b0, 1'b0));
        send(32'h0001_FFFF, 32'h0003_0000, mk(32'h2AAA_D556, 1'b0, 1'b0, 1'b0));
        send(32'h8000_8000, 32'h8000_8000, mk(32'h7FFF_0000, 1'b1, 1'b0, 1'b0));
        drain();

        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        send(32'h2000_0000, 32'h4000_0000, mk(32'h4000_0000, 1'b0, 1'b0, 1'b0));
        for (int t = 0; t < 40 && !bus0.out_valid; t++) @(negedge clk);
        chk("stall_reach_done", 64'(bus0.out_valid), 64'd1);
        cap = bus0.c;
        bad = 0;
        bus0.a = 32'h7FFF_7FFF;
        bus0.in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus0.c !== cap || bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1) bad++;
        end
        bus0.in_valid = 1'b0;
        chk("stall_hold", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        drain();

        send(32'h3000_1000, 32'h2000_5000, model(32'h3000_1000, 32'h2000_5000));
        repeat (3) @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("rst_mid0", 64'({bus0.out_valid, bus0.c}), 64'd0);
        chk("rst_mid1", 64'({bus1.out_valid, bus1.c}), 64'd0);
        q0.delete();
        q1.delete();
        seen0 = 1'b0;
        seen1 = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("rst_release", 64'({bus0.in_ready, bus1.in_ready}), 64'd3);
        @(posedge clk);
        #1;
        send(32'h1000_2000, 32'h0000_4000, mk(32'h4000_E000, 1'b0, 1'b0, 1'b0));
        drain();

        rand_rdy = 1'b1;
        repeat (1000) begin
            mode = $urandom_range(0, 9);
            av = {rnd_part(mode == 3 ? 3 : 0), rnd_part(mode == 3 ? 3 : 0)};
            bv = {rnd_part(mode), rnd_part(mode)};
            if (mode == 0) bv = '0;
            if (mode == 2) av = '0;
            send(av, bv, model(av, bv));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
